neuron_sequencer: RTL and testbench

NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

---
 rtl/neuron_pkg.sv | 19 +
 rtl/neuron_sequencer.sv | 138 +++++++++++++
 tb/tb_neuron_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared types and defaults for the neuron evaluation sequencer.
// State encoding plus the default sizing for inputs and address width.
package neuron_pkg;

  localparam int N_MAX_DEF  = 256;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    MAC,
    DRAIN,
    BIAS_LD,
    BIAS_ADD,
    ACT,
    DONE
  } state_t;

endpackage

// File: rtl/neuron_sequencer.sv
// Control sequencer for one neuron: clear, N multiply-accumulates, bias, ReLU.
// Define NEURON_SEQ_BIAS_EN to include the bias load/add states.
module neuron_sequencer
  import neuron_pkg::*;
#(
  parameter int N_MAX  = N_MAX_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] n_inputs,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              mac_clr,
  output logic              mul_en,
  output logic              acc_en,
  output logic              bias_ld,
  output logic              bias_add,
  output logic              act_cap,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   n_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                acc_q;
  logic                err_q;
  logic                n_ok;
  logic                take;
  logic                kill;
  logic                last;

  assign n_ok = (n_inputs != '0) &&
                ({1'b0, n_inputs} <= (ADDR_W+1)'(N_MAX));
  assign take = (state_q == IDLE) && start && n_ok;
  assign kill = abort && (state_q != IDLE);
  assign last = (addr_q == n_q - ADDR_W'(1));

  assign addr   = addr_q;
  assign acc_en = acc_q;
  assign err    = err_q;

  // Next-state and strobe decode; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    src_ready = 1'b0;
    mac_clr   = 1'b0;
    mul_en    = 1'b0;
    bias_ld   = 1'b0;
    bias_add  = 1'b0;
    act_cap   = 1'b0;
    done      = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (take) state_d = CLR;
      end
      CLR: begin
        mac_clr = 1'b1;
        state_d = MAC;
      end
      MAC: begin
        src_ready = 1'b1;
        if (src_valid) begin
          mul_en = 1'b1;
          if (last) state_d = DRAIN;
        end
      end
      DRAIN: begin
`ifdef NEURON_SEQ_BIAS_EN
        state_d = BIAS_LD;
`else
        state_d = ACT;
`endif
      end
`ifdef NEURON_SEQ_BIAS_EN
      BIAS_LD: begin
        src_ready = 1'b1;
        if (src_valid) begin
          bias_ld = 1'b1;
          state_d = BIAS_ADD;
        end
      end
      BIAS_ADD: begin
        bias_add = 1'b1;
        state_d  = ACT;
      end
`endif
      ACT: begin
        act_cap = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d   = IDLE;
      src_ready = 1'b0;
      mac_clr   = 1'b0;
      mul_en    = 1'b0;
      bias_ld   = 1'b0;
      bias_add  = 1'b0;
      act_cap   = 1'b0;
      done      = 1'b0;
    end
  end

  // State, latched count, index counter, product stage and error flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      acc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= mul_en;
      err_q   <= start && !take && !kill;
      if (take) n_q <= n_inputs;
      if (state_q == CLR || state_d == IDLE) begin
        addr_q <= '0;
      end else if (mul_en) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Self-checking bench for neuron_sequencer: vector table, directed
// corner sequences and randomized evaluations against a timeline model.
module tb_neuron_sequencer;

  localparam int AW = 9;
`ifdef NEURON_SEQ_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] n_inputs = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [AW-1:0] addr;
  logic          mac_clr;
  logic          mul_en;
  logic          acc_en;
  logic          bias_ld;
  logic          bias_add;
  logic          act_cap;
  logic          busy;
  logic          done;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  neuron_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .n_inputs  (n_inputs),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .addr      (addr),
    .mac_clr   (mac_clr),
    .mul_en    (mul_en),
    .acc_en    (acc_en),
    .bias_ld   (bias_ld),
    .bias_add  (bias_add),
    .act_cap   (act_cap),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic          st;
    logic [AW-1:0] n;
    logic          e_err;
    logic          e_busy;
    logic          e_clr;
  } vec_t;

  vec_t tv[7];

  function automatic logic [9:0] outs();
    return {src_ready, mac_clr, mul_en, acc_en, bias_ld,
            bias_add, act_cap, busy, done, err};
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic a,
                      input logic [AW-1:0] n, input logic v);
    @(negedge clk);
    start     = s;
    abort     = a;
    n_inputs  = n;
    src_valid = v;
    #1;
  endtask

  // Evaluation model: expected strobes derived from the src_valid pattern.
  task automatic run_eval(input int n, input int mode, input int inj,
                          output int done_at);
    bit         val[0:1023];
    int         t_last, t_bl, t_act, t_done, cnt, hs;
    int         mul_n, acc_n, done_n, e_addr;
    logic       a_chk;
    logic [9:0] e;
    for (int k = 0; k < 1024; k++) begin
      case (mode)
        0:       val[k] = 1'b1;
        1:       val[k] = (k % 3) != 0;
        default: val[k] = $urandom_range(0, 3) != 0;
      endcase
      if (k >= 1000) val[k] = 1'b1;
    end
    cnt = 0;
    t_last = 0;
    for (int k = 2; k < 1024 && cnt < n; k++) begin
      if (val[k]) begin
        cnt++;
        t_last = k;
      end
    end
    t_bl = t_last + 1;
    if (BIAS) begin
      t_bl = t_last + 2;
      while (!val[t_bl]) t_bl++;
      t_act = t_bl + 2;
    end else begin
      t_act = t_last + 2;
    end
    t_done = t_act + 1;
    hs = 0;
    mul_n = 0;
    acc_n = 0;
    done_n = 0;
    done_at = -1;
    for (int k = 0; k <= t_done; k++) begin
      step(k == 0 || k == inj, 1'b0,
           (k == 0) ? AW'(n) : AW'(7), val[k]);
      e[9] = (k >= 2 && k <= t_last) ||
             (BIAS && k >= t_last + 2 && k <= t_bl);
      e[8] = (k == 1);
      e[7] = (k >= 2 && k <= t_last && val[k]);
      e[6] = (k >= 3 && k - 1 <= t_last && val[k-1]);
      e[5] = BIAS && (k == t_bl);
      e[4] = BIAS && (k == t_bl + 1);
      e[3] = (k == t_act);
      e[2] = (k >= 1);
      e[1] = (k == t_done);
      e[0] = (inj >= 0) && (k == inj + 1);
      chk($sformatf("eval_outs n=%0d cyc=%0d", n, k),
          32'(outs()), 32'(e));
      a_chk = 1'b0;
      e_addr = 0;
      if (k >= 2 && k <= t_last) begin
        a_chk = 1'b1;
        e_addr = hs;
      end else if (BIAS && k >= t_last + 2 && k <= t_bl) begin
        a_chk = 1'b1;
        e_addr = n;
      end
      if (a_chk) begin
        chk($sformatf("eval_addr n=%0d cyc=%0d", n, k),
            32'(addr), e_addr);
      end
      if (e[7]) hs++;
      if (mul_en) mul_n++;
      if (acc_en) acc_n++;
      if (done) begin
        done_n++;
        done_at = k;
      end
    end
    chk($sformatf("mul_count n=%0d", n), mul_n, n);
    chk($sformatf("acc_count n=%0d", n), acc_n, n);
    chk($sformatf("done_count n=%0d", n), done_n, 1);
  endtask

  initial begin
    int         d;
    logic [9:0] o;

    tv[0] = '{1'b1, 9'd0,   1'b1, 1'b0, 1'b0};
    tv[1] = '{1'b1, 9'd257, 1'b1, 1'b0, 1'b0};
    tv[2] = '{1'b1, 9'd511, 1'b1, 1'b0, 1'b0};
    tv[3] = '{1'b0, 9'd4,   1'b0, 1'b0, 1'b0};
    tv[4] = '{1'b1, 9'd1,   1'b0, 1'b1, 1'b1};
    tv[5] = '{1'b1, 9'd256, 1'b0, 1'b1, 1'b1};
    tv[6] = '{1'b1, 9'd300, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 9'd4, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_addr", 32'(addr), 32'd0);
    rst = 1'b0;

    foreach (tv[i]) begin
      step(tv[i].st, 1'b0, tv[i].n, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      o = outs();
      chk($sformatf("vec%0d_err_busy_clr", i),
          32'({o[0], o[2], o[8]}),
          32'({tv[i].e_err, tv[i].e_busy, tv[i].e_clr}));
      chk($sformatf("vec%0d_addr", i), 32'(addr), 32'd0);
      abort = tv[i].e_busy;
      step(1'b0, 1'b0, '0, 1'b0);
      chk($sformatf("vec%0d_idle", i), 32'(outs()), 32'd0);
    end

    run_eval(4, 0, -1, d);
    chk("n4_done_cycle", d, BIAS ? 10 : 8);

    run_eval(5, 0, 3, d);

    step(1'b1, 1'b0, 9'd10, 1'b1);
    for (int k = 1; k <= 7; k++) step(1'b0, 1'b0, '0, 1'b1);
    chk("abort_pre_addr", 32'(addr), 32'd5);
    chk("abort_pre_mul", 32'(mul_en), 32'd1);
    start = 1'b1;
    abort = 1'b1;
    n_inputs = 9'd3;
    step(1'b0, 1'b0, '0, 1'b0);
    o = outs();
    chk("abort_idle", 32'(o[9:1]), 32'd0);
    run_eval(3, 0, -1, d);

    step(1'b1, 1'b0, 9'd4, 1'b1);
    for (int k = 1; k <= 7; k++) step(1'b0, 1'b0, '0, 1'b1);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);
    chk("rst_mid_outs", 32'(outs()), 32'd0);
    chk("rst_mid_addr", 32'(addr), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      chk($sformatf("rst_after_%0d", k), 32'(outs()), 32'd0);
    end

    run_eval(1, 0, -1, d);
    chk("n1_done_cycle", d, BIAS ? 7 : 5);

    run_eval(256, 1, -1, d);

    for (int r = 0; r < 25; r++) begin
      int rn;
      int ri;
      rn = int'($urandom_range(1, 24));
      ri = -1;
      if ($urandom_range(0, 1) == 1) ri = int'($urandom_range(1, rn + 3));
      run_eval(rn, 2, ri, d);
    end

    run_eval(256, 2, 100, d);

    step(1'b0, 1'b0, '0, 1'b0);
    chk("final_idle", 32'(outs()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
